// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: instruction-memory port, redirect inputs and the
// presented-instruction outputs with their status counters.
interface fetch_ctrl_if #(
    parameter int WORD_W  = 64,
    parameter int INSTR_W = 32
);
    logic [WORD_W-1:0]  imem_pc;
    logic [INSTR_W-1:0] imem_instr;
    logic               stall;
    logic               branch_taken;
    logic [WORD_W-1:0]  branch_target;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [WORD_W-1:0]  if_pc;
    logic               halted;
    logic [31:0]        fetch_count;
    logic [31:0]        stall_count;

    modport master (
        output imem_pc, if_valid, if_instr, if_pc, halted, fetch_count, stall_count,
        input  imem_instr, stall, branch_taken, branch_target
    );

    modport slave (
        input  imem_pc, if_valid, if_instr, if_pc, halted, fetch_count, stall_count,
        output imem_instr, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller for a synchronous instruction memory: sequential
// fetch, zero-bubble redirect, stall hold by re-reading, and halt detection.
module fetch_ctrl #(
    parameter int                 WORD_W     = 64,
    parameter int                 INSTR_W    = 32,
    parameter logic [WORD_W-1:0]  RESET_PC   = '0,
    parameter logic [WORD_W-1:0]  PC_STEP    = WORD_W'(4),
    parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(32'hD4400000)
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);
    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_W-1:0] rsp_pc_q, rsp_pc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic [31:0]       stall_count_q, stall_count_d;

    logic if_valid;
    logic hold;
    logic accept;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign if_valid = rsp_valid_q && (state_q == RUN);
    assign hold     = if_valid && bus.stall;
    assign accept   = if_valid && !bus.stall && !bus.branch_taken;

    // Holding re-presents rsp_pc to the memory so the word on imem_instr stays put.
    always_comb begin
        if (bus.branch_taken)
            bus.imem_pc = bus.branch_target;
        else if (hold)
            bus.imem_pc = rsp_pc_q;
        else
            bus.imem_pc = fetch_pc_q;
    end

    assign bus.if_valid    = if_valid;
    assign bus.if_instr    = bus.imem_instr;
    assign bus.if_pc       = rsp_pc_q;
    assign bus.halted      = (state_q == HALT);
    assign bus.fetch_count = fetch_count_q;
    assign bus.stall_count = stall_count_q;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        rsp_valid_d   = rsp_valid_q;
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        case (state_q)
            BOOT: begin
                state_d     = RUN;
                rsp_pc_d    = RESET_PC;
                fetch_pc_d  = RESET_PC + PC_STEP;
                rsp_valid_d = 1'b1;
            end
            RUN: begin
                if (bus.branch_taken) begin
                    rsp_pc_d    = bus.branch_target;
                    fetch_pc_d  = bus.branch_target + PC_STEP;
                    rsp_valid_d = 1'b1;
                end else if (hold) begin
                    stall_count_d = sat_inc(stall_count_q);
                end else if (accept && bus.if_instr == HALT_INSTR) begin
                    // Halt freezes fetch_pc at the word after the halt instruction.
                    state_d       = HALT;
                    rsp_valid_d   = 1'b0;
                    fetch_count_d = sat_inc(fetch_count_q);
                end else begin
                    rsp_pc_d    = fetch_pc_q;
                    fetch_pc_d  = fetch_pc_q + PC_STEP;
                    rsp_valid_d = 1'b1;
                    if (accept)
                        fetch_count_d = sat_inc(fetch_count_q);
                end
            end
            HALT: begin
                if (bus.branch_taken) begin
                    state_d     = RUN;
                    rsp_pc_d    = bus.branch_target;
                    fetch_pc_d  = bus.branch_target + PC_STEP;
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            rsp_valid_q   <= 1'b0;
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            rsp_valid_q   <= rsp_valid_d;
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot stream, stall hold, redirect, halt and
// asynchronous reset, against a synchronous instruction-memory model.
module tb_fetch_ctrl;
    localparam logic [31:0] HALT_W = 32'hD4400000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic halt_en = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_ctrl_if #(.WORD_W(64), .INSTR_W(32)) bus ();

    fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a, input logic hen);
        if (hen && a == 64'h20)
            return HALT_W;
        return 32'h1300_0000 | {8'h00, a[23:0]};
    endfunction

    always @(posedge clk)
        bus.imem_instr <= mem_word(bus.imem_pc, halt_en);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        tick();
        tick();
        chk("rst_if_valid", {63'd0, bus.if_valid}, 64'd0);
        chk("rst_halted", {63'd0, bus.halted}, 64'd0);
        chk("rst_imem_pc", bus.imem_pc, 64'd0);
        chk("rst_fcnt", {32'd0, bus.fetch_count}, 64'd0);
        chk("rst_scnt", {32'd0, bus.stall_count}, 64'd0);
        reset = 1'b0;
        tick();
        chk("boot_valid", {63'd0, bus.if_valid}, 64'd1);
        chk("boot_pc0", bus.if_pc, 64'h0);
        chk("boot_instr0", {32'd0, bus.if_instr}, {32'd0, mem_word(64'h0, 1'b0)});
        chk("boot_imem_pc", bus.imem_pc, 64'h4);
        tick();
        chk("boot_pc4", bus.if_pc, 64'h4);
        tick();
        chk("boot_pc8", bus.if_pc, 64'h8);
        chk("boot_fcnt2", {32'd0, bus.fetch_count}, 64'd2);

        // Stall hold at 8 for three cycles
        bus.stall = 1'b1;
        #1;
        chk("stall_imem_pc", bus.imem_pc, 64'h8);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("stall_if_pc", bus.if_pc, 64'h8);
            chk("stall_instr", {32'd0, bus.if_instr}, {32'd0, mem_word(64'h8, 1'b0)});
            chk("stall_imem_pc_hold", bus.imem_pc, 64'h8);
            chk("stall_cnt", {32'd0, bus.stall_count}, 64'(i));
        end
        chk("stall_fcnt", {32'd0, bus.fetch_count}, 64'd2);
        bus.stall = 1'b0;
        tick();
        chk("post_stall_pc", bus.if_pc, 64'hC);
        tick();
        chk("stream_pc16", bus.if_pc, 64'h10);
        chk("stream_fcnt4", {32'd0, bus.fetch_count}, 64'd4);

        // Redirect from 0x10 to 0x100
        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h100;
        #1;
        chk("br_imem_pc", bus.imem_pc, 64'h100);
        tick();
        bus.branch_taken = 1'b0;
        chk("br_pc", bus.if_pc, 64'h100);
        chk("br_instr", {32'd0, bus.if_instr}, {32'd0, mem_word(64'h100, 1'b0)});
        chk("br_fcnt", {32'd0, bus.fetch_count}, 64'd4);
        tick();
        chk("br_pc_next", bus.if_pc, 64'h104);
        chk("br_fcnt_next", {32'd0, bus.fetch_count}, 64'd5);

        // Branch and stall together
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h40;
        tick();
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        chk("brst_pc", bus.if_pc, 64'h40);
        chk("brst_scnt", {32'd0, bus.stall_count}, 64'd3);
        chk("brst_fcnt", {32'd0, bus.fetch_count}, 64'd5);

        // Reach the halt word at 0x20
        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h1C;
        tick();
        bus.branch_taken = 1'b0;
        halt_en          = 1'b1;
        chk("pre_halt_pc", bus.if_pc, 64'h1C);
        tick();
        chk("halt_pc", bus.if_pc, 64'h20);
        chk("halt_instr", {32'd0, bus.if_instr}, {32'd0, HALT_W});
        chk("halt_fcnt_pre", {32'd0, bus.fetch_count}, 64'd6);
        tick();
        chk("halted", {63'd0, bus.halted}, 64'd1);
        chk("halt_valid", {63'd0, bus.if_valid}, 64'd0);
        chk("halt_imem_pc", bus.imem_pc, 64'h24);
        chk("halt_fcnt", {32'd0, bus.fetch_count}, 64'd7);
        bus.stall = 1'b1;
        tick();
        chk("halt_stall_imem_pc", bus.imem_pc, 64'h24);
        chk("halt_stall_scnt", {32'd0, bus.stall_count}, 64'd3);
        chk("halt_still", {63'd0, bus.halted}, 64'd1);
        bus.stall         = 1'b0;
        halt_en           = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h0;
        tick();
        bus.branch_taken = 1'b0;
        chk("unhalt", {63'd0, bus.halted}, 64'd0);
        chk("unhalt_valid", {63'd0, bus.if_valid}, 64'd1);
        chk("unhalt_pc", bus.if_pc, 64'h0);
        tick();
        chk("unhalt_pc4", bus.if_pc, 64'h4);

        // Asynchronous reset in the middle of a stall
        bus.stall = 1'b1;
        tick();
        chk("pre_rst_scnt", {32'd0, bus.stall_count}, 64'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", {63'd0, bus.if_valid}, 64'd0);
        chk("arst_halted", {63'd0, bus.halted}, 64'd0);
        chk("arst_imem_pc", bus.imem_pc, 64'h0);
        chk("arst_fcnt", {32'd0, bus.fetch_count}, 64'd0);
        chk("arst_scnt", {32'd0, bus.stall_count}, 64'd0);
        tick();
        reset     = 1'b0;
        bus.stall = 1'b0;
        tick();
        chk("restart_valid", {63'd0, bus.if_valid}, 64'd1);
        chk("restart_pc", bus.if_pc, 64'h0);
        tick();
        chk("restart_pc4", bus.if_pc, 64'h4);
        chk("restart_fcnt", {32'd0, bus.fetch_count}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- WORD_W, 64, PC/address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, sequential address increment.
- HALT_INSTR, 32'hD4400000, encoding that stops fetch.

REQ-002 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.

REQ-003 The block SHALL have these ports:
- clk, in, 1, clock.
- reset, in, 1, async active-high reset.
- imem_pc, out, WORD_W, address to the synchronous instruction memory, which is sampled at posedge.
- imem_instr, in, INSTR_W, memory read data; it holds the word for the address sampled at the previous posedge.
- stall, in, 1, downstream not ready.
- branch_taken, in, 1, redirect request.
- branch_target, in, WORD_W, redirect address.
- if_valid, out, 1, instruction presented.
- if_instr, out, INSTR_W, presented instruction.
- if_pc, out, WORD_W, its address.
- halted, out, 1, fetch stopped.
- fetch_count, out, 32, accepted instructions.
- stall_count, out, 32, stalled cycles.

Function
REQ-004 The block SHALL use internal registers fetch_pc (next sequential address), rsp_pc (address of the word on imem_instr), rsp_valid, and state in {BOOT, RUN, HALT}.

REQ-005 The block SHALL drive outputs as follows:
- if_instr = imem_instr.
- if_pc = rsp_pc.
- if_valid = rsp_valid AND state==RUN.
- halted = (state==HALT).

REQ-006 imem_pc SHALL be combinational, with priority in this order:
- branch_taken: branch_target.
- hold (if_valid AND stall): rsp_pc.
- otherwise: fetch_pc.

REQ-007 The block SHALL define accept = if_valid AND NOT stall AND NOT branch_taken.

REQ-008 BOOT SHALL go to RUN at the first posedge after reset release, setting rsp_pc<=RESET_PC, rsp_valid<=1 and fetch_pc<=RESET_PC+PC_STEP, so that if_valid rises one cycle after reset release.

REQ-009 In RUN with branch_taken, at the posedge the block SHALL set rsp_pc<=branch_target, fetch_pc<=branch_target+PC_STEP and rsp_valid<=1, giving a zero-bubble redirect. The instruction presented in the branch cycle SHALL be discarded and not counted.

REQ-010 In RUN with hold and no branch, the block SHALL leave all address registers unchanged; the memory re-reads rsp_pc, so if_instr and if_pc stay stable across the stall.

REQ-011 In RUN with accept, the block SHALL set rsp_pc<=fetch_pc and fetch_pc<=fetch_pc+PC_STEP.

REQ-012 In RUN with rsp_valid==0 and no branch, the block SHALL behave as accept (advance) without counting.

REQ-013 When accept occurs and if_instr==HALT_INSTR, the block SHALL go to HALT at that posedge and clear rsp_valid. The HALT instruction itself SHALL be counted.

REQ-014 In HALT, if_valid SHALL be 0 and imem_pc SHALL equal fetch_pc. branch_taken SHALL perform the REQ-009 redirect and return to RUN. stall SHALL be ignored.

REQ-015 branch_taken SHALL have priority over stall and over HALT detection when they coincide.

REQ-016 Address arithmetic SHALL wrap modulo 2^WORD_W with no error indication.

REQ-017 fetch_count SHALL increment on each accept, and stall_count on each hold cycle without branch_taken. Both SHALL saturate at 32'hFFFFFFFF.

REQ-018 branch_taken in BOOT SHALL be ignored.

Reset
REQ-019 While reset is high, asynchronously:
- state=BOOT, fetch_pc=RESET_PC, rsp_pc=RESET_PC, rsp_valid=0.
- Both counters = 0.
- if_valid=0, halted=0.
- imem_pc=RESET_PC unless branch_taken is high.

REQ-020 Reset asserted mid-operation, including mid-stall or in HALT, SHALL abandon all state immediately, and the sequence SHALL restart per REQ-008.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Boot stream: release reset, stall=0 -> if_valid rises the next cycle; if_pc reads 0, 4, 8, 12 on consecutive cycles; fetch_count=4 after 4 accepts.
- Stall hold: stall high 3 cycles while if_pc=8 -> if_pc=8 and if_instr unchanged for 3 cycles, imem_pc=8, stall_count=3; after release if_pc=12 the next cycle.
- Redirect: branch_taken with target 0x100 while if_pc=0x10 -> next cycle if_pc=0x100, following cycle 0x104; the 0x10 instruction is not counted.
- Branch during stall: stall and branch_taken together, target 0x40 -> next cycle if_pc=0x40; stall_count unchanged in that cycle.
- Halt: HALT_INSTR accepted at 0x20 -> halted=1 and if_valid=0 the next cycle; imem_pc stays 0x24; branch to 0x0 restores RUN with if_pc=0.
- Async reset mid-stall: reset pulsed between clock edges -> outputs at reset values immediately; counters 0; stream restarts at RESET_PC.
